// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the single-cycle MIPS core.
// Receives a framed byte stream (16-bit big-endian word count, big-endian
// instruction words, XOR checksum), writes the words to consecutive
// instruction-memory addresses and keeps the core in reset until a complete,
// checksum-verified program is in memory.
//
// Handshake: a byte transfers on a rising edge where rx_valid && rx_ready.
// rx_ready is high in LEN_HI, LEN_LO, DATA and CHECK, low in DONE, ERROR and
// while reset is asserted. The block never back-pressures inside a frame,
// so a producer may present one byte per cycle.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [15:0]           words_loaded
);

  // Largest accepted word count; 17 bits so 2^16 would still be representable.
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t state;
  state_t next_state;

  logic [7:0]            len_hi;
  logic [15:0]           frame_len;
  logic [15:0]           len_in;
  logic [1:0]            byte_cnt;
  logic [23:0]           asm_word;
  logic [7:0]            xor_acc;
  logic [ADDR_WIDTH:0]   idx;
  logic [ADDR_WIDTH:0]   idx_next;
  logic                  accept;
  logic                  write_word;
  logic                  chk_match;
  logic                  chk_fail;
  logic                  len_reject;

  assign rx_ready = !reset && ((state == S_LEN_HI) || (state == S_LEN_LO) ||
                               (state == S_DATA)   || (state == S_CHECK));
  assign accept   = rx_valid && rx_ready;
  assign len_in   = {len_hi, rx_data};
  // The index counter has one spare bit so a full-capacity load ends at
  // 2^ADDR_WIDTH without wrapping back to zero.
  assign idx_next = idx + {{ADDR_WIDTH{1'b0}}, 1'b1};

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_LEN_HI;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and single-cycle event strobes for the datapath.
  always_comb begin
    next_state = state;
    write_word = 1'b0;
    chk_match  = 1'b0;
    chk_fail   = 1'b0;
    len_reject = 1'b0;
    case (state)
      S_LEN_HI: begin
        if (accept) next_state = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) begin
          if ({1'b0, len_in} > CAPACITY) begin
            next_state = S_ERROR;
            len_reject = 1'b1;
          end else if (len_in == 16'd0) begin
            next_state = S_CHECK;
          end else begin
            next_state = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept && (byte_cnt == 2'd3)) begin
          write_word = 1'b1;
          if (16'(idx_next) == frame_len) next_state = S_CHECK;
        end
      end
      S_CHECK: begin
        if (accept) begin
          if (rx_data == xor_acc) begin
            next_state = S_DONE;
            chk_match  = 1'b1;
          end else begin
            next_state = S_ERROR;
            chk_fail   = 1'b1;
          end
        end
      end
      default: begin
        next_state = state;
      end
    endcase
  end

  // Datapath: length capture, word assembly, checksum, memory write port
  // and the sticky status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      len_hi       <= 8'd0;
      frame_len    <= 16'd0;
      byte_cnt     <= 2'd0;
      asm_word     <= 24'd0;
      xor_acc      <= 8'd0;
      idx          <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
      words_loaded <= 16'd0;
      cpu_reset    <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      imem_we <= write_word;
      if (accept && (state != S_CHECK)) xor_acc <= xor_acc ^ rx_data;
      if (accept && (state == S_LEN_HI)) len_hi <= rx_data;
      if (accept && (state == S_LEN_LO)) frame_len <= len_in;
      if (accept && (state == S_DATA)) begin
        byte_cnt <= byte_cnt + 2'd1;
        asm_word <= {asm_word[15:0], rx_data};
      end
      if (write_word) begin
        imem_addr    <= idx[ADDR_WIDTH-1:0];
        imem_wdata   <= {asm_word, rx_data};
        idx          <= idx_next;
        words_loaded <= 16'(idx_next);
      end
      if (chk_match) begin
        cpu_reset <= 1'b0;
        load_done <= 1'b1;
      end
      if (chk_fail || len_reject) load_error <= 1'b1;
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the single-cycle MIPS core and its instruction memory. It accepts a framed byte stream (length header, instruction words, checksum) over a valid/ready byte interface. It assembles big-endian 32-bit words, writes them to consecutive instruction-memory word addresses, and holds the core in reset until a complete, checksum-verified program has been loaded.

## Interface
- ADDR_WIDTH, 8, instruction-memory word-address width; capacity = 2^ADDR_WIDTH words (256 by default)
- clock  in  1  single system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high; returns block to LEN_HI
- rx_data  in  8  incoming stream byte
- rx_valid  in  1  rx_data is valid this cycle
- rx_ready  out  1  block accepts a byte this cycle; a byte transfers on a rising edge where rx_valid && rx_ready
- imem_we  out  1  one-cycle instruction-memory write strobe
- imem_addr  out  ADDR_WIDTH  word address for the write (byte address = imem_addr << 2)
- imem_wdata  out  32  assembled instruction word
- cpu_reset  out  1  drives core reset; high until load succeeds
- load_done  out  1  program loaded and verified
- load_error  out  1  frame rejected
- words_loaded  out  16  count of words written in the current frame

## Operation
- Frame format: LEN_HI, LEN_LO (N = 16-bit word count, big-endian), 4·N data bytes (each word MSB first), then CHK.
- CHK must equal the XOR of all preceding frame bytes, including both length bytes.
- State machine, reset state LEN_HI:
  - LEN_HI: accept a byte, latch length[15:8], go to LEN_LO.
  - LEN_LO: accept a byte, latch length[7:0]. Then:
    - N > 2^ADDR_WIDTH: go to ERROR.
    - N == 0: go to CHECK.
    - Otherwise: go to DATA.
  - DATA: shift bytes into a 32-bit assembly register. On the 4th byte of a word, copy the word to imem_wdata and pulse imem_we. After word N-1 is written, go to CHECK.
  - CHECK: accept one byte. Match: go to DONE. Mismatch: go to ERROR.
  - DONE and ERROR: terminal; left only by reset.
- rx_ready = 1 in LEN_HI, LEN_LO, DATA and CHECK. rx_ready = 0 in DONE, ERROR, and while reset is high.
- No back-pressure during DATA. Bytes may arrive back-to-back every cycle.
- Word index counter (ADDR_WIDTH+1 bits):
  - Increments on each write.
  - imem_addr = index of the word being written.
  - words_loaded = number of writes completed in this frame.
- Running XOR is updated on every accepted byte except CHK itself.
- Gaps in rx_valid: state, partial word and checksum are held unchanged.
- Memory contents are never cleared. A rejected frame may leave partially written words.

## Timing
- Reset values:
  - rx_ready = 0 during the reset cycle, 1 afterwards.
  - imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - cpu_reset = 1, load_done = 0, load_error = 0, words_loaded = 0.
- Write latency: imem_we is high for exactly the one cycle after the edge that accepts a word's 4th byte. imem_addr and imem_wdata are registered and stable in that cycle.
- words_loaded updates on the same edge that raises imem_we.
- Completion: on the edge that accepts a matching CHK, cpu_reset falls to 0 and load_done rises to 1, both registered.
  - The last data word's imem_we occurs at least one cycle before cpu_reset falls.
  - The core's first fetch therefore sees a completely written memory.
- Error: load_error rises on the edge that accepts a mismatching CHK, or on the edge that accepts an over-length LEN_LO. cpu_reset stays 1.
- Outputs once latched: load_done and load_error stay set until reset; they are never both 1.
- Reset mid-frame, on the next edge:
  - Return to LEN_HI.
  - Clear the partial word, XOR accumulator and counters.
  - Force cpu_reset to 1.
  - An imem_we scheduled for that edge is suppressed.
- Boundary: N = 2^ADDR_WIDTH is accepted. The last write is at imem_addr = 2^ADDR_WIDTH − 1, and the index counter does not alias.

## Test plan
- Nominal load: bytes 00 02 20 08 00 05 20 09 00 03 05, back-to-back → two imem_we pulses:
  - addr 0, data 0x20080005.
  - addr 1, data 0x20090003.
  - Then cpu_reset 1→0, load_done = 1, words_loaded = 2, rx_ready = 0.
- Bad checksum: same frame with CHK = 06 → both writes occur, load_error = 1, cpu_reset stays 1, load_done = 0.
- Over-length: 01 01 (N = 257, ADDR_WIDTH = 8) → load_error = 1 the cycle after LEN_LO, no imem_we, rx_ready = 0.
- Empty program: 00 00 00 → load_done = 1, no imem_we, words_loaded = 0.
- Stalled stream: nominal frame with rx_valid randomly low 50% of cycles → identical writes and result; no write between a word's bytes.
- Reset mid-frame: assert reset after the 6th byte, then send the nominal frame → first write at addr 0 with 0x20080005, final load_done = 1.
